// File: rtl/regfile_access_ctrl_pkg.sv
// Shared definitions for the register-file access controller: default widths
// and the per-cycle action encoding used by the controller and its bench-facing strobes.
package regfile_access_ctrl_pkg;

  localparam int unsigned DEF_DATA_W   = 16;
  localparam int unsigned DEF_ID_W     = 4;
  localparam int unsigned DEF_WB_DEPTH = 4;

  // Exactly one of these is taken per clock cycle.
  typedef enum logic [1:0] {
    ACT_IDLE  = 2'd0,
    ACT_READ  = 2'd1,
    ACT_WRITE = 2'd2
  } act_e;

endpackage

// File: rtl/regfile_wb_fifo.sv
// Writeback buffer: WB_DEPTH x {dst, data} circular FIFO.
// Ports:
//   clk, reset        clock / async active-low reset (contents discarded)
//   push, push_dst, push_data   enqueue (ignored while full, no bypass)
//   pop               dequeue head (ignored while empty)
//   head_dst, head_data         current head entry
//   full, empty, empty_next     occupancy now / after this cycle's push+pop
//   entry_valid, entry_dst      per-slot occupancy and dst for hazard compare
module regfile_wb_fifo
  import regfile_access_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ID_W     = DEF_ID_W,
  parameter int unsigned WB_DEPTH = DEF_WB_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [ID_W-1:0]          push_dst,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [ID_W-1:0]          head_dst,
  output logic [DATA_W-1:0]        head_data,
  output logic                     full,
  output logic                     empty,
  output logic                     empty_next,
  output logic [WB_DEPTH-1:0]      entry_valid,
  output logic [WB_DEPTH*ID_W-1:0] entry_dst
);

  localparam int unsigned PTR_W = $clog2(WB_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic [ID_W-1:0]   dst_mem  [WB_DEPTH];
  logic [DATA_W-1:0] data_mem [WB_DEPTH];
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count_q == CNT_W'(WB_DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign head_dst  = dst_mem[rd_ptr_q];
  assign head_data = data_mem[rd_ptr_q];

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  assign empty_next = (count_d == '0);

  // Slot i is occupied when its distance from the read pointer is below the count.
  always_comb begin
    entry_valid = '0;
    entry_dst   = '0;
    for (int unsigned i = 0; i < WB_DEPTH; i++) begin
      entry_valid[i]              = CNT_W'(PTR_W'(PTR_W'(i) - rd_ptr_q)) < count_q;
      entry_dst[i*ID_W +: ID_W]   = dst_mem[i];
    end
  end

  // Pointers and count; power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // Entry storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < WB_DEPTH; i++) begin
        dst_mem[i]  <= '0;
        data_mem[i] <= '0;
      end
    end else if (push_ok) begin
      dst_mem[wr_ptr_q]  <= push_dst;
      data_mem[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Initiator side of a dual-port register file. Sequences operand reads (port 1+2)
// and buffered writebacks (port 2 only), stalling reads that hit a buffered dst.
// Ports:
//   clk, reset                         clock / async active-low reset
//   req_valid/ready, req_src1/2        operand-read request
//   rsp_valid/ready, rsp_data1/2       registered operand response
//   wb_valid/ready, wb_dst, wb_data    writeback request into the FIFO
//   flush_req, flush_done              drain request / registered drained indication
//   rf_rd1/wn1/rd2/wn2, rf_id1/2, rf_wdata1/2, rf_rdata1/2   register-file port
module regfile_access_ctrl
  import regfile_access_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ID_W     = DEF_ID_W,
  parameter int unsigned WB_DEPTH = DEF_WB_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ID_W-1:0]   req_src1,
  input  logic [ID_W-1:0]   req_src2,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data1,
  output logic [DATA_W-1:0] rsp_data2,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ID_W-1:0]   wb_dst,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush_req,
  output logic              flush_done,
  output logic              rf_rd1,
  output logic              rf_wn1,
  output logic              rf_rd2,
  output logic              rf_wn2,
  output logic [ID_W-1:0]   rf_id1,
  output logic [ID_W-1:0]   rf_id2,
  output logic [DATA_W-1:0] rf_wdata1,
  output logic [DATA_W-1:0] rf_wdata2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2
);

  logic [ID_W-1:0]          head_dst;
  logic [DATA_W-1:0]        head_data;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     fifo_empty_next;
  logic [WB_DEPTH-1:0]      entry_valid;
  logic [WB_DEPTH*ID_W-1:0] entry_dst;
  logic                     hazard;
  act_e                     act;

  regfile_wb_fifo #(
    .DATA_W   (DATA_W),
    .ID_W     (ID_W),
    .WB_DEPTH (WB_DEPTH)
  ) u_wb_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (wb_valid),
    .push_dst    (wb_dst),
    .push_data   (wb_data),
    .pop         (act == ACT_WRITE),
    .head_dst    (head_dst),
    .head_data   (head_data),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .empty_next  (fifo_empty_next),
    .entry_valid (entry_valid),
    .entry_dst   (entry_dst)
  );

  assign wb_ready = !fifo_full;

  // RAW hazard: either source matches any buffered dst, including the head being written.
  always_comb begin
    hazard = 1'b0;
    for (int unsigned i = 0; i < WB_DEPTH; i++) begin
      if (entry_valid[i] && ((entry_dst[i*ID_W +: ID_W] == req_src1) ||
                             (entry_dst[i*ID_W +: ID_W] == req_src2))) begin
        hazard = 1'b1;
      end
    end
  end

  // Action select: a full FIFO or a flush forces writes; reads beat background drain.
  always_comb begin
    act = ACT_IDLE;
    if (!reset) begin
      act = ACT_IDLE;
    end else if (fifo_full || flush_req) begin
      act = fifo_empty ? ACT_IDLE : ACT_WRITE;
    end else if (req_valid && !hazard && (!rsp_valid || rsp_ready)) begin
      act = ACT_READ;
    end else if (!fifo_empty) begin
      act = ACT_WRITE;
    end
  end

  // Register-file strobes follow the action of the current cycle.
  always_comb begin
    req_ready = 1'b0;
    rf_rd1    = 1'b0;
    rf_rd2    = 1'b0;
    rf_wn1    = 1'b0;
    rf_wn2    = 1'b0;
    rf_id1    = '0;
    rf_id2    = '0;
    rf_wdata1 = '0;
    rf_wdata2 = '0;
    case (act)
      ACT_READ: begin
        req_ready = 1'b1;
        rf_rd1    = 1'b1;
        rf_rd2    = 1'b1;
        rf_id1    = req_src1;
        rf_id2    = req_src2;
      end
      ACT_WRITE: begin
        rf_wn2    = 1'b1;
        rf_id2    = head_dst;
        rf_wdata2 = head_data;
      end
      default: begin
      end
    endcase
  end

  // Response register: a READ reloads it even while the old response is being consumed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid <= 1'b0;
      rsp_data1 <= '0;
      rsp_data2 <= '0;
    end else if (act == ACT_READ) begin
      rsp_valid <= 1'b1;
      rsp_data1 <= rf_rdata1;
      rsp_data2 <= rf_rdata2;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  // Flush completion, using post-edge occupancy so it rises right after the last pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flush_done <= 1'b0;
    end else begin
      flush_done <= flush_req && fifo_empty_next;
    end
  end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
module tb_regfile_access_ctrl;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ID_W     = 4;
  localparam int unsigned WB_DEPTH = 4;
  localparam int unsigned NREG     = 16;

  typedef struct packed {
    logic [ID_W-1:0]   dst;
    logic [DATA_W-1:0] data;
  } wb_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic [ID_W-1:0]   req_src1;
  logic [ID_W-1:0]   req_src2;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data1;
  logic [DATA_W-1:0] rsp_data2;
  logic              wb_valid;
  logic              wb_ready;
  logic [ID_W-1:0]   wb_dst;
  logic [DATA_W-1:0] wb_data;
  logic              flush_req;
  logic              flush_done;
  logic              rf_rd1, rf_wn1, rf_rd2, rf_wn2;
  logic [ID_W-1:0]   rf_id1, rf_id2;
  logic [DATA_W-1:0] rf_wdata1, rf_wdata2;
  logic [DATA_W-1:0] rf_rdata1, rf_rdata2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  regfile_access_ctrl #(
    .DATA_W(DATA_W), .ID_W(ID_W), .WB_DEPTH(WB_DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_src1(req_src1), .req_src2(req_src2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data1(rsp_data1), .rsp_data2(rsp_data2),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_dst(wb_dst), .wb_data(wb_data),
    .flush_req(flush_req), .flush_done(flush_done),
    .rf_rd1(rf_rd1), .rf_wn1(rf_wn1), .rf_rd2(rf_rd2), .rf_wn2(rf_wn2),
    .rf_id1(rf_id1), .rf_id2(rf_id2),
    .rf_wdata1(rf_wdata1), .rf_wdata2(rf_wdata2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2)
  );

  // Environment register file: preloaded R[i]=i+5 while in reset, written via port strobes.
  logic [DATA_W-1:0] env_r [NREG];
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < int'(NREG); i++) env_r[i] <= DATA_W'(i + 5);
    end else begin
      if (rf_wn1) env_r[rf_id1] <= rf_wdata1;
      if (rf_wn2) env_r[rf_id2] <= rf_wdata2;
    end
  end
  assign rf_rdata1 = env_r[rf_id1];
  assign rf_rdata2 = env_r[rf_id2];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Behavioural model: queue of pending writebacks, architectural register image,
  // pending response. Checked and advanced once per cycle on the falling edge.
  wb_t               m_q[$];
  logic [DATA_W-1:0] m_r [NREG];
  logic              m_rv;
  logic [DATA_W-1:0] m_d1, m_d2;
  logic              m_fd;

  always @(negedge clk) begin
    bit hz, do_rd, do_wr, full, empty;
    logic [ID_W-1:0]   e_id2;
    logic [DATA_W-1:0] e_wd2;
    if (!reset) begin
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rf_strobes", 32'({rf_rd1, rf_wn1, rf_rd2, rf_wn2}), 32'd0);
      chk("rst_rf_ids", 32'({rf_id1, rf_id2}), 32'd0);
      chk("rst_rf_wdata", 32'({rf_wdata1, rf_wdata2}), 32'd0);
      chk("rst_wb_ready", 32'(wb_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_data", 32'({rsp_data1, rsp_data2}), 32'd0);
      chk("rst_flush_done", 32'(flush_done), 32'd0);
      m_q.delete();
      for (int i = 0; i < int'(NREG); i++) m_r[i] = DATA_W'(i + 5);
      m_rv = 1'b0; m_d1 = '0; m_d2 = '0; m_fd = 1'b0;
    end else begin
      full  = (m_q.size() == int'(WB_DEPTH));
      empty = (m_q.size() == 0);
      hz = 1'b0;
      foreach (m_q[i]) if (m_q[i].dst == req_src1 || m_q[i].dst == req_src2) hz = 1'b1;
      do_rd = 1'b0; do_wr = 1'b0;
      if (full || flush_req)                            do_wr = !empty;
      else if (req_valid && !hz && (!m_rv || rsp_ready)) do_rd = 1'b1;
      else                                              do_wr = !empty;
      e_id2 = do_rd ? req_src2 : (do_wr ? m_q[0].dst : '0);
      e_wd2 = do_wr ? m_q[0].data : '0;

      chk("req_ready", 32'(req_ready), 32'(do_rd));
      chk("rf_rd1", 32'(rf_rd1), 32'(do_rd));
      chk("rf_rd2", 32'(rf_rd2), 32'(do_rd));
      chk("rf_wn1", 32'(rf_wn1), 32'd0);
      chk("rf_wn2", 32'(rf_wn2), 32'(do_wr));
      chk("rf_id1", 32'(rf_id1), do_rd ? 32'(req_src1) : 32'd0);
      chk("rf_id2", 32'(rf_id2), 32'(e_id2));
      chk("rf_wdata1", 32'(rf_wdata1), 32'd0);
      chk("rf_wdata2", 32'(rf_wdata2), 32'(e_wd2));
      chk("wb_ready", 32'(wb_ready), 32'(!full));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
      chk("rsp_data1", 32'(rsp_data1), 32'(m_d1));
      chk("rsp_data2", 32'(rsp_data2), 32'(m_d2));
      chk("flush_done", 32'(flush_done), 32'(m_fd));

      // Advance the model to the state after the coming rising edge.
      if (do_rd) begin
        m_rv = 1'b1; m_d1 = m_r[req_src1]; m_d2 = m_r[req_src2];
      end else if (m_rv && rsp_ready) begin
        m_rv = 1'b0;
      end
      if (do_wr) begin
        m_r[m_q[0].dst] = m_q[0].data;
        void'(m_q.pop_front());
      end
      if (wb_valid && !full) m_q.push_back('{dst: wb_dst, data: wb_data});
      m_fd = flush_req && (m_q.size() == 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_src1 = '0; req_src2 = '0; rsp_ready = 1'b1;
    wb_valid = 1'b0; wb_dst = '0; wb_data = '0; flush_req = 1'b0;
    step(); step();
    reset = 1'b1;
    step();

    // Basic read: R[3]=8, R[7]=12.
    req_valid = 1'b1; req_src1 = 4'd3; req_src2 = 4'd7; rsp_ready = 1'b1;
    #2;
    chk("d1_rd_strobes", 32'({rf_rd1, rf_rd2, req_ready}), 32'h7);
    chk("d1_rf_id1", 32'(rf_id1), 32'd3);
    step();
    chk("d1_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("d1_rsp_data1", 32'(rsp_data1), 32'd8);
    chk("d1_rsp_data2", 32'(rsp_data2), 32'd12);
    req_valid = 1'b0;

    // Writeback to R2, then a read of R2 stalls behind it.
    wb_valid = 1'b1; wb_dst = 4'd2; wb_data = 16'hBEEF;
    step();
    wb_valid = 1'b0; req_valid = 1'b1; req_src1 = 4'd2; req_src2 = 4'd0;
    #2;
    chk("d2_stall_req_ready", 32'(req_ready), 32'd0);
    chk("d2_write_port2", 32'({rf_wn2, rf_id2, rf_wdata2}), {11'd0, 1'b1, 4'd2, 16'hBEEF});
    step();
    #2;
    chk("d2_read_resumes", 32'(req_ready), 32'd1);
    step();
    chk("d2_rsp_data1", 32'(rsp_data1), 32'hBEEF);
    chk("d2_rsp_data2", 32'(rsp_data2), 32'd5);
    req_valid = 1'b0;

    // Fill the FIFO while reads win; full then forces a write.
    req_valid = 1'b1; req_src1 = 4'd1; req_src2 = 4'd4;
    for (int k = 0; k < 4; k++) begin
      wb_valid = 1'b1; wb_dst = ID_W'(8 + k); wb_data = DATA_W'(16'h1000 + k);
      #2;
      chk("d3_wb_ready_fill", 32'(wb_ready), 32'd1);
      step();
    end
    wb_valid = 1'b0;
    #2;
    chk("d3_full_wb_ready", 32'(wb_ready), 32'd0);
    chk("d3_forced_write", 32'({req_ready, rf_wn2, rf_id2}), {26'd0, 1'b0, 1'b1, 4'd8});
    step();
    #2;
    chk("d3_read_after_full", 32'({req_ready, wb_ready}), 32'h3);
    step();

    // Consumer back-pressure: response held, reads blocked, FIFO drains its 3 entries.
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #2;
      chk("d4_hold_rsp", 32'({rsp_valid, rsp_data1}), {15'd0, 1'b1, 16'd6});
      chk("d4_hold_data2", 32'(rsp_data2), 32'd9);
      chk("d4_blocked_drain", 32'({req_ready, rf_wn2}), 32'h1);
      step();
    end
    rsp_ready = 1'b1; req_valid = 1'b0;
    step();

    // Flush with three buffered entries.
    req_valid = 1'b1; req_src1 = 4'd1; req_src2 = 4'd4;
    for (int k = 0; k < 3; k++) begin
      wb_valid = 1'b1; wb_dst = ID_W'(12 + k); wb_data = DATA_W'(16'h2000 + k);
      step();
    end
    wb_valid = 1'b0; flush_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #2;
      chk("d5_flush_write", 32'({req_ready, rf_wn2, flush_done}), 32'h2);
      chk("d5_flush_id", 32'(rf_id2), 32'(12 + k));
      step();
    end
    #2;
    chk("d5_flush_done", 32'({flush_done, rf_wn2}), 32'h2);
    flush_req = 1'b0; req_valid = 1'b0;
    step();

    // Reset in the middle of a drain with a pending response.
    req_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      wb_valid = 1'b1; wb_dst = ID_W'(k); wb_data = DATA_W'(16'h3000 + k);
      step();
    end
    wb_valid = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    #2;
    chk("d6_draining", 32'(rf_wn2), 32'd1);
    step();
    reset = 1'b0;
    #1;
    chk("d6_rst_wn2", 32'(rf_wn2), 32'd0);
    chk("d6_rst_wb_ready", 32'(wb_ready), 32'd1);
    chk("d6_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    step();
    reset = 1'b1; rsp_ready = 1'b1;
    step();

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      req_valid = ($urandom_range(0, 9) < 7);
      req_src1  = ID_W'($urandom_range(0, 7));
      req_src2  = ID_W'($urandom_range(0, 7));
      rsp_ready = ($urandom_range(0, 9) < 7);
      wb_valid  = ($urandom_range(0, 9) < 5);
      wb_dst    = ID_W'($urandom_range(0, 7));
      wb_data   = DATA_W'($urandom);
      if ($urandom_range(0, 99) < 4) flush_req = !flush_req;
      reset     = ($urandom_range(0, 399) != 0);
      step();
    end
    reset = 1'b1; req_valid = 1'b0; wb_valid = 1'b0; flush_req = 1'b0;
    repeat (8) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
